// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - first-word-fall-through FIFO with valid/ready on both sides
// Occupancy is tracked by an explicit count; pointers simply wrap by overflow.
module stream_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_W-1:0]      count
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push, pop;

  // Flags come from registered count only, so ready/valid never loop combinationally.
  assign s_ready = (count_q != FULL_CNT);
  assign m_valid = (count_q != '0);
  assign m_data  = mem_q[rd_ptr_q];
  assign count   = count_q;

  assign push = s_valid & s_ready;
  assign pop  = m_valid & m_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // A flush drops any coincident push, so the write is gated by clr as well.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !clr) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

endmodule

// File: tb/tb_stream_fifo.sv
// tb/tb_stream_fifo.sv - directed scoreboard bench for stream_fifo
module tb_stream_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic [2:0]  count;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] sb[$];
  bit          seen_beef = 1'b0;

  stream_fifo #(.DATA_WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check outputs against the scoreboard, then clock one edge and update the model.
  task automatic cyc(input string tag, input logic sv, input logic [15:0] sd,
                     input logic mr, input logic cl);
    int  n;
    bit  do_push, do_pop;
    s_valid = sv; s_data = sd; m_ready = mr; clr = cl;
    #1;
    n = sb.size();
    check({tag, ".count"},   32'(count),   32'(n));
    check({tag, ".s_ready"}, 32'(s_ready), 32'(n != 4));
    check({tag, ".m_valid"}, 32'(m_valid), 32'(n != 0));
    if (n != 0) check({tag, ".m_data"}, 32'(m_data), 32'(sb[0]));
    if (m_valid && m_data == 16'hBEEF) seen_beef = 1'b1;
    do_push = sv && (n != 4) && !cl;
    do_pop  = mr && (n != 0) && !cl;
    @(posedge clk);
    if (cl) sb.delete();
    else begin
      if (do_pop)  void'(sb.pop_front());
      if (do_push) sb.push_back(sd);
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    #1;
    check("rst.count",   32'(count),   32'd0);
    check("rst.s_ready", 32'(s_ready), 32'd1);
    check("rst.m_valid", 32'(m_valid), 32'd0);
    check("rst.m_data",  32'(m_data),  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Mid-stream asynchronous reset at count 3
    cyc("pre1", 1, 16'h0A01, 0, 0);
    cyc("pre2", 1, 16'h0A02, 0, 0);
    cyc("pre3", 1, 16'h0A03, 0, 0);
    s_valid = 1'b0;
    #1;
    check("pre.count", 32'(count), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    sb.delete();
    check("arst.count",   32'(count),   32'd0);
    check("arst.m_valid", 32'(m_valid), 32'd0);
    check("arst.s_ready", 32'(s_ready), 32'd1);
    check("arst.m_data",  32'(m_data),  32'd0);
    m_ready = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b1;
    cyc("post_rst1", 0, 16'h0, 1, 0);
    cyc("post_rst2", 0, 16'h0, 1, 0);

    // Fill to full, then hold a fifth word against backpressure
    cyc("fill1", 1, 16'h0011, 0, 0);
    cyc("fill2", 1, 16'h0022, 0, 0);
    cyc("fill3", 1, 16'h0033, 0, 0);
    cyc("fill4", 1, 16'h0044, 0, 0);
    cyc("hold1", 1, 16'h0055, 0, 0);
    cyc("hold2", 1, 16'h0055, 0, 0);

    // Drain in order; 0x0055 slips in one cycle after the first pop
    cyc("drain1", 1, 16'h0055, 1, 0);
    cyc("drain2", 1, 16'h0055, 1, 0);
    for (int i = 0; i < 5; i++) cyc("drain", 0, 16'h0, 1, 0);

    // Simultaneous push/pop at occupancy 2, pointers wrap several times
    cyc("pp_pre1", 1, 16'h0100, 0, 0);
    cyc("pp_pre2", 1, 16'h0101, 0, 0);
    for (int i = 0; i < 10; i++) cyc("pp", 1, 16'h0102 + 16'(i), 1, 0);
    check("pp.count_end", 32'(count), 32'd2);
    for (int i = 0; i < 3; i++) cyc("pp_drain", 0, 16'h0, 1, 0);

    // Full with simultaneous pop: pop proceeds, push waits one cycle
    for (int i = 0; i < 4; i++) cyc("f5_fill", 1, 16'h0200 + 16'(i), 0, 0);
    cyc("f5_both", 1, 16'h0299, 1, 0);
    check("f5.count_after_pop", 32'(count), 32'd3);
    cyc("f5_push", 1, 16'h0299, 0, 0);
    check("f5.count_after_push", 32'(count), 32'd4);
    for (int i = 0; i < 5; i++) cyc("f5_drain", 0, 16'h0, 1, 0);

    // Flush has priority over coincident push and pop
    for (int i = 0; i < 3; i++) cyc("fl_fill", 1, 16'h0300 + 16'(i), 0, 0);
    cyc("fl_clr", 1, 16'hBEEF, 1, 1);
    check("fl.count",   32'(count),   32'd0);
    check("fl.m_valid", 32'(m_valid), 32'd0);
    for (int i = 0; i < 3; i++) cyc("fl_after", 0, 16'h0, 1, 0);
    check("fl.no_beef", 32'(seen_beef), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
